// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with per-character status and a
// receive FIFO drained by the host.
//
// Host port handshake: rd_valid is high whenever the FIFO holds at least one
// entry and rd_data/rd_status then show the head entry; the head is consumed
// on every clock edge where rd_valid and rd_ready are both high, and it stays
// stable while rd_valid is high and rd_ready is low.
module uart_rx_fifo #(
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_en,
    input  logic                          rx,
    input  logic [1:0]                    parity,
    input  logic [2:0]                    data_bits,
    input  logic                          stop_bits,
    input  logic [DIV_W-1:0]              rx_divisor,
    input  logic                          rd_ready,
    input  logic                          ovr_clr,
    output logic                          rd_valid,
    output logic [8:0]                    rd_data,
    output logic [2:0]                    rd_status,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          rx_busy,
    output logic                          rx_timeout
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

    localparam logic [IDX_W-1:0] IDX_S0   = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_S1   = IDX_W'(OVERSAMPLE / 2);
    localparam logic [IDX_W-1:0] IDX_S2   = IDX_W'(OVERSAMPLE / 2 + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_BITS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_e;

    state_e state_q, state_d;

    // ---------------- line input path ----------------
    logic sync1_q, sync2_q, line_q;
    logic start_edge;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            line_q  <= 1'b1;
        end else begin
            sync1_q <= rx_en ? rx : 1'b1;
            sync2_q <= sync1_q;
            line_q  <= sync2_q;
        end
    end

    assign start_edge = (state_q == S_IDLE) && line_q && !sync2_q;

    // ---------------- configuration latch ----------------
    logic [3:0]       nbits_in;
    logic [DIV_W-1:0] div_in;
    logic             par_en_q, par_odd_q, stop2_q;
    logic [3:0]       nbits_q;
    logic [DIV_W-1:0] div_q;

    // Decode the data length code into a bit count.
    always_comb begin
        nbits_in = 4'd8;
        case (data_bits)
            3'd0:    nbits_in = 4'd5;
            3'd1:    nbits_in = 4'd6;
            3'd2:    nbits_in = 4'd7;
            3'd3:    nbits_in = 4'd8;
            3'd4:    nbits_in = 4'd9;
            default: nbits_in = 4'd8;
        endcase
    end

    assign div_in = (rx_divisor == '0) ? DIV_W'(1) : rx_divisor;

    // Freeze the frame format at the start edge so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            nbits_q   <= 4'd8;
            div_q     <= DIV_W'(1);
        end else if (start_edge) begin
            par_en_q  <= (parity == 2'b01) || (parity == 2'b10);
            par_odd_q <= (parity == 2'b01);
            stop2_q   <= stop_bits;
            nbits_q   <= nbits_in;
            div_q     <= div_in;
        end
    end

    // ---------------- tick generator ----------------
    logic [DIV_W-1:0] div_cnt_q, div_reload;
    logic [IDX_W-1:0] samp_idx_q;
    logic             tick, dec, bit_end;

    // While idle the generator keeps running on the live divisor so the
    // character timeout can count bit periods.
    assign div_reload = (state_q == S_IDLE) ? (div_in - DIV_W'(1)) : (div_q - DIV_W'(1));
    assign tick       = (div_cnt_q == '0);
    assign dec        = tick && (samp_idx_q == IDX_S2);
    assign bit_end    = tick && (samp_idx_q == IDX_LAST);

    // Divider and per-bit sample index; both realign on every start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            samp_idx_q <= '0;
        end else if (start_edge) begin
            div_cnt_q  <= div_in - DIV_W'(1);
            samp_idx_q <= '0;
        end else if (tick) begin
            div_cnt_q  <= div_reload;
            samp_idx_q <= (samp_idx_q == IDX_LAST) ? '0 : samp_idx_q + 1'b1;
        end else begin
            div_cnt_q  <= div_cnt_q - DIV_W'(1);
        end
    end

    // ---------------- majority voter ----------------
    logic s0_q, s1_q, maj;

    // Capture the two early mid-bit samples; the third is the live line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q <= 1'b1;
            s1_q <= 1'b1;
        end else if (tick) begin
            if (samp_idx_q == IDX_S0) s0_q <= sync2_q;
            if (samp_idx_q == IDX_S1) s1_q <= sync2_q;
        end
    end

    assign maj = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);

    // ---------------- frame FSM ----------------
    logic [8:0]  data_q;
    logic [3:0]  bit_cnt_q;
    logic        par_bit_q, perr_q, ferr_q, stop_cnt_q;
    logic        data_wr, bit_adv, par_wr, stop_adv, ferr_set;
    logic        push_d, push_q;
    logic [11:0] push_word_d, push_word_q;
    logic        is_break, par_expect;

    assign par_expect = par_odd_q ? ~(^data_q) : (^data_q);
    assign is_break   = (data_q == '0) && (!par_en_q || !par_bit_q) && !maj;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and per-bit control strobes.
    always_comb begin
        state_d     = state_q;
        data_wr     = 1'b0;
        bit_adv     = 1'b0;
        par_wr      = 1'b0;
        stop_adv    = 1'b0;
        ferr_set    = 1'b0;
        push_d      = 1'b0;
        push_word_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_START;
            end
            S_START: begin
                if (dec && maj)   state_d = S_IDLE;
                else if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (dec) data_wr = 1'b1;
                if (bit_end) begin
                    bit_adv = 1'b1;
                    if (bit_cnt_q == nbits_q - 4'd1)
                        state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (dec)     par_wr  = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Completing at the decision point leaves time to catch a
                // start bit that follows the last stop bit immediately.
                if (dec) begin
                    if (!stop_cnt_q && is_break) begin
                        push_d      = 1'b1;
                        push_word_d = {1'b1, 1'b0, 1'b1, 9'd0};
                        state_d     = S_BRK_WAIT;
                    end else if (stop_cnt_q == stop2_q) begin
                        push_d      = 1'b1;
                        push_word_d = {1'b0, perr_q, ferr_q | ~maj, data_q};
                        state_d     = S_IDLE;
                    end else begin
                        ferr_set = !maj;
                    end
                end else if (bit_end) begin
                    stop_adv = 1'b1;
                end
            end
            S_BRK_WAIT: begin
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath: data bits land directly at their final position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            bit_cnt_q   <= '0;
            par_bit_q   <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            stop_cnt_q  <= 1'b0;
            push_q      <= 1'b0;
            push_word_q <= '0;
        end else begin
            if (start_edge) begin
                data_q     <= '0;
                bit_cnt_q  <= '0;
                par_bit_q  <= 1'b0;
                perr_q     <= 1'b0;
                ferr_q     <= 1'b0;
                stop_cnt_q <= 1'b0;
            end else begin
                if (data_wr) begin
                    for (int i = 0; i < 9; i++)
                        if (bit_cnt_q == 4'(i)) data_q[i] <= maj;
                end
                if (bit_adv)  bit_cnt_q <= bit_cnt_q + 4'd1;
                if (par_wr) begin
                    par_bit_q <= maj;
                    perr_q    <= (maj != par_expect);
                end
                if (ferr_set) ferr_q     <= 1'b1;
                if (stop_adv) stop_cnt_q <= 1'b1;
            end
            push_q      <= push_d;
            push_word_q <= push_word_d;
        end
    end

    assign rx_busy = (state_q != S_IDLE);

    // ---------------- receive FIFO ----------------
    logic [11:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
    logic           full, pop, push_ok;
    logic [11:0]    head;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign rd_valid   = (fifo_count != '0);
    assign full       = (fifo_count == DEPTH_C);
    assign pop        = rd_valid && rd_ready;
    assign push_ok    = push_q && (!full || pop);
    assign head       = mem[rd_ptr_q[PTR_W-1:0]];
    assign rd_data    = rd_valid ? head[8:0]  : 9'd0;
    assign rd_status  = rd_valid ? head[11:9] : 3'd0;

    // Storage array; contents are only visible through a valid head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= push_word_q;
    end

    // Pointers; a push into a full FIFO only lands if a pop frees a slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Sticky overrun; a dropped character wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)                      overrun <= 1'b0;
        else if (push_q && full && !pop) overrun <= 1'b1;
        else if (ovr_clr)                overrun <= 1'b0;
    end

    // ---------------- character timeout ----------------
    logic [TO_W-1:0] to_cnt_q;
    logic            to_run, to_clr;

    assign to_run = (state_q == S_IDLE) && rd_valid;
    assign to_clr = start_edge || pop || !rd_valid;

    // Count idle bit periods with data waiting, saturating at the threshold.
    always_ff @(posedge clk) begin
        if (!rst_n || to_clr)
            to_cnt_q <= '0;
        else if (to_run && bit_end && (to_cnt_q != TO_MAX))
            to_cnt_q <= to_cnt_q + 1'b1;
    end

    assign rx_timeout = (to_cnt_q == TO_MAX);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames, scoreboard on the host port.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n, rx_en, rx_line, stop_bits, rd_ready, ovr_clr;
    logic [1:0]  parity;
    logic [2:0]  data_bits;
    logic [15:0] rx_divisor;
    logic        rd_valid, overrun, rx_busy, rx_timeout;
    logic [8:0]  rd_data;
    logic [2:0]  rd_status;
    logic [3:0]  fifo_count;

    logic [11:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    bit          ready_en = 1'b0;
    bit          scramble_cfg = 1'b0;
    bit          model_ovr = 1'b0;

    uart_rx_fifo #(.OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(40)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx(rx_line), .parity(parity),
        .data_bits(data_bits), .stop_bits(stop_bits), .rx_divisor(rx_divisor),
        .rd_ready(rd_ready), .ovr_clr(ovr_clr), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_status(rd_status), .fifo_count(fifo_count), .overrun(overrun),
        .rx_busy(rx_busy), .rx_timeout(rx_timeout)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #3_000_000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int len);
        rx_line = b;
        tick_wait(len);
    endtask

    task automatic sb_push(input logic [11:0] e);
        if (exp_q.size() >= DEPTH) model_ovr = 1'b1;
        else exp_q.push_back(e);
    endtask

    // host-side ready driver
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = ready_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // monitor: every accepted head entry is compared with the oldest expectation
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_entry: got status=%b data=0x%0h, expected none", rd_status, rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("fifo_entry", {rd_status, rd_data}, e);
                end
            end
        end
    end

    // Build one frame on the line and predict its FIFO entry from the bits sent.
    task automatic send_frame(input logic [8:0] d, input logic [2:0] db, input logic [1:0] par,
                              input logic sb, input logic flip, input logic [1:0] bad,
                              input logic [15:0] dv, input int gap, input bit chk_busy);
        int n, bl, ones;
        logic [8:0] dat;
        logic par_en, pbit, s1, s2, brk, perr, ferr;
        n   = (db <= 3'd4) ? int'(db) + 5 : 8;
        bl  = 16 * ((dv == 16'd0) ? 1 : int'(dv));
        dat = '0;
        for (int i = 0; i < n; i++) dat[i] = d[i];
        par_en = (par == 2'b01) || (par == 2'b10);
        ones   = $countones(dat);
        pbit   = (par == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
        pbit   = pbit ^ flip;
        s1 = ~bad[0];
        s2 = ~bad[1];
        brk  = (dat == 9'd0) && (!par_en || !pbit) && !s1;
        perr = par_en && (((ones + int'(pbit)) % 2) != ((par == 2'b01) ? 1 : 0));
        ferr = !s1 || (sb && !s2);
        sb_push(brk ? 12'hA00 : {1'b0, perr, ferr, dat});
        parity = par; data_bits = db; stop_bits = sb; rx_divisor = dv;
        if (chk_busy) begin
            rx_line = 1'b0;
            tick_wait(4);
            check("busy_latency", rx_busy, 1);
            tick_wait(bl - 4);
        end else begin
            drive_bit(1'b0, bl);
        end
        if (scramble_cfg) begin
            parity = 2'($urandom); data_bits = 3'($urandom);
            stop_bits = 1'($urandom); rx_divisor = 16'($urandom_range(1, 9));
        end
        for (int i = 0; i < n; i++) drive_bit(dat[i], bl);
        if (par_en) drive_bit(pbit, bl);
        drive_bit(s1, bl);
        if (sb) drive_bit(s2, bl);
        drive_bit(1'b1, bl * gap);
        check("busy_after_frame", rx_busy, 0);
    endtask

    task automatic drain();
        int t = 0;
        ready_en = 1'b1;
        while ((exp_q.size() != 0 || rd_valid) && t < 4000) begin
            tick_wait(1);
            t++;
        end
        check("drain_done", (exp_q.size() == 0 && !rd_valid), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_status"}, rd_status, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_rx_busy"}, rx_busy, 0);
        check({tag, "_rx_timeout"}, rx_timeout, 0);
    endtask

    initial begin
        logic [8:0]  d;
        logic [15:0] dv;
        // reset
        rst_n = 1'b0; rx_en = 1'b1; rx_line = 1'b1; ovr_clr = 1'b0;
        parity = 2'b00; data_bits = 3'd3; stop_bits = 1'b0; rx_divisor = 16'd4;
        tick_wait(4);
        rst_n = 1'b1;
        tick_wait(1);
        check_reset_values("reset");
        ready_en = 1'b1;

        // 8N1 basic
        send_frame(9'h0A5, 3'd3, 2'b00, 1'b0, 1'b0, 2'b00, 16'd4, 1, 1'b1);
        drain();

        // 9E2 with inverted parity and bad second stop bit
        send_frame(9'h1F3, 3'd4, 2'b10, 1'b1, 1'b1, 2'b10, 16'd4, 1, 1'b0);
        drain();

        // false start: low for 3 ticks
        rx_divisor = 16'd4;
        rx_line = 1'b0;
        tick_wait(8);
        check("glitch_busy", rx_busy, 1);
        tick_wait(4);
        drive_bit(1'b1, 128);
        check("false_start_idle", rx_busy, 0);
        check("false_start_count", fifo_count, 0);

        // receiver disabled: low line is ignored
        rx_en = 1'b0;
        drive_bit(1'b0, 128);
        check("disabled_busy", rx_busy, 0);
        rx_line = 1'b1;
        tick_wait(4);
        rx_en = 1'b1;
        tick_wait(4);

        // break for two character times, then a normal frame
        parity = 2'b00; data_bits = 3'd3; stop_bits = 1'b0; rx_divisor = 16'd4;
        sb_push(12'hA00);
        drive_bit(1'b0, 20 * 64);
        drive_bit(1'b1, 2 * 64);
        check("break_idle", rx_busy, 0);
        send_frame(9'h03C, 3'd3, 2'b00, 1'b0, 1'b0, 2'b00, 16'd4, 1, 1'b0);
        drain();

        // overrun: DEPTH+1 characters with the host stalled
        ready_en = 1'b0;
        model_ovr = 1'b0;
        tick_wait(2);
        for (int i = 0; i < DEPTH + 1; i++)
            send_frame(9'($urandom_range(0, 255)), 3'd3, 2'b00, 1'b0, 1'b0, 2'b00, 16'd4, 1, 1'b0);
        check("ovr_fifo_count", fifo_count, exp_q.size());
        check("ovr_flag", overrun, model_ovr);
        check("ovr_head", {rd_status, rd_data}, exp_q[0]);
        ovr_clr = 1'b1;
        tick_wait(1);
        ovr_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        drain();

        // character timeout
        ready_en = 1'b0;
        tick_wait(2);
        send_frame(9'h05A, 3'd3, 2'b00, 1'b0, 1'b0, 2'b00, 16'd4, 1, 1'b0);
        tick_wait(36 * 64);
        check("timeout_early", rx_timeout, 0);
        tick_wait(4 * 64);
        check("timeout_set", rx_timeout, 1);
        drain();
        tick_wait(1);
        check("timeout_cleared", rx_timeout, 0);

        // reset in the middle of the data bits
        rx_divisor = 16'd4;
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 64);
        drive_bit(1'b0, 64);
        drive_bit(1'b1, 32);
        rst_n = 1'b0;
        rx_line = 1'b1;
        tick_wait(2);
        check_reset_values("midreset");
        rst_n = 1'b1;
        tick_wait(3 * 64);
        check("midreset_no_push", fifo_count, 0);
        check("midreset_idle", rx_busy, 0);

        // randomized traffic with format changes after each start bit
        scramble_cfg = 1'b1;
        ready_en = 1'b1;
        for (int f = 0; f < 30; f++) begin
            case ($urandom_range(0, 3))
                0: dv = 16'd0;
                1: dv = 16'd1;
                2: dv = 16'd2;
                default: dv = 16'd4;
            endcase
            d = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom);
            send_frame(d, 3'($urandom), 2'($urandom), 1'($urandom),
                       1'($urandom_range(0, 3) == 0),
                       {1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0)},
                       dv, $urandom_range(1, 3), 1'b0);
        end
        drain();
        check("final_overrun", overrun, 0);
        check("final_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
